// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD digit constants and helpers for the up/down counter.
package bcd_updown_counter_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Non-decimal codes (A..F) collapse to zero so the count never leaves 0..9.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? BCD_MIN : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loads, increments or decrements, and reports carry/borrow to the next decade.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             co,
  output logic             bo
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  // Load wins over counting; inc and dec are never both set by the top.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = bcd_sanitize(ld_val);
    end else if (inc) begin
      q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = inc && (q_q == BCD_MAX);
  assign bo = dec && (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaler, parallel load and full-scale wrap pulse.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    step,
  output logic                    wrap
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic          step_q;
  logic          step_d;
  logic          wrap_q;
  logic          wrap_d;
  logic          step_evt_c;
  logic [DIGITS:0] inc_chain;
  logic [DIGITS:0] dec_chain;

  assign step_evt_c = en && (pcnt_q == PCNT_LAST);

  // Prescaler holds while disabled; a load restarts the interval.
  always_comb begin
    pcnt_d = pcnt_q;
    if (load) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = step_evt_c ? '0 : pcnt_q + PW'(1);
    end
  end

  // A step coinciding with a load is discarded, so no pulse either.
  always_comb begin
    step_d = step_evt_c && !load;
    wrap_d = step_d && (inc_chain[DIGITS] || dec_chain[DIGITS]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign inc_chain[0] = step_evt_c && up;
  assign dec_chain[0] = step_evt_c && !up;

  // Carry/borrow ripples combinationally from digit 0 upward within the step cycle.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc_chain[i]),
      .dec    (dec_chain[i]),
      .ld     (load),
      .ld_val (load_val[BCD_W*i +: BCD_W]),
      .q      (bcd[BCD_W*i +: BCD_W]),
      .co     (inc_chain[i+1]),
      .bo     (dec_chain[i+1])
    );
  end

  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed-vector bench for bcd_updown_counter with DIGITS=2, PRESCALE=4.
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd;
  logic       step;
  logic       wrap;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] lv;
    logic [7:0] eb;
    logic       es;
    logic       ew;
  } vec_t;

  vec_t vecs[$];

  bcd_updown_counter #(.DIGITS(2), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .step     (step),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [7:0] lv, input logic [7:0] eb, input logic es, input logic ew);
    vec_t v;
    v = '{r, e, u, l, lv, eb, es, ew};
    vecs.push_back(v);
  endtask

  // n-1 quiet cycles holding prev, then the step cycle showing nxt.
  task automatic add_steps(input logic u, input int n, input logic [7:0] prev,
                           input logic [7:0] nxt, input logic ew);
    for (int i = 0; i < n - 1; i++) add(1'b0, 1'b1, u, 1'b0, 8'h00, prev, 1'b0, 1'b0);
    add(1'b0, 1'b1, u, 1'b0, 8'h00, nxt, 1'b1, ew);
  endtask

  task automatic apply(input string nm, input logic r, input logic e, input logic u,
                       input logic l, input logic [7:0] lv, input logic [7:0] eb,
                       input logic es, input logic ew);
    rst = r; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    #1;
    n_vec++;
    if (bcd !== eb || step !== es || wrap !== ew) begin
      n_miss++;
      $display("FAIL %s #%0d: got bcd=%h step=%b wrap=%b, expected bcd=%h step=%b wrap=%b",
               nm, n_vec, bcd, step, wrap, eb, es, ew);
    end
  endtask

  initial begin
    int dec_n;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'h00;

    // Reset, including reset overriding load and enable.
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(1, 1, 1, 1, 8'h77, 8'h00, 0, 0);

    // 40 clocks counting up: one step every 4 clocks, reaching 10.
    for (int k = 1; k <= 40; k++) begin
      dec_n = k / 4;
      add(0, 1, 1, 0, 8'h00, {4'(dec_n / 10), 4'(dec_n % 10)}, (k % 4) == 0, 0);
    end

    // Up wrap 99 -> 00 with a single-cycle wrap pulse.
    add(0, 1, 1, 1, 8'h98, 8'h98, 0, 0);
    add_steps(1, 4, 8'h98, 8'h99, 0);
    add_steps(1, 4, 8'h99, 8'h00, 1);
    add_steps(1, 4, 8'h00, 8'h01, 0);

    // Down wrap 00 -> 99, then plain decrement and cross-digit borrow.
    add(0, 1, 0, 1, 8'h00, 8'h00, 0, 0);
    add_steps(0, 4, 8'h00, 8'h99, 1);
    add_steps(0, 4, 8'h99, 8'h98, 0);
    add(0, 1, 0, 1, 8'h10, 8'h10, 0, 0);
    add_steps(0, 4, 8'h10, 8'h09, 0);

    // Illegal digits load as zero, per digit.
    add(0, 0, 1, 1, 8'hB7, 8'h07, 0, 0);
    add(0, 0, 1, 1, 8'h3F, 8'h30, 0, 0);
    add(0, 0, 1, 1, 8'hA0, 8'h00, 0, 0);

    // Load held for several cycles tracks load_val, no steps.
    add(0, 1, 1, 1, 8'h12, 8'h12, 0, 0);
    add(0, 1, 1, 1, 8'h34, 8'h34, 0, 0);
    add(0, 1, 1, 1, 8'hA9, 8'h09, 0, 0);
    add(0, 1, 1, 1, 8'h78, 8'h78, 0, 0);
    add(0, 1, 1, 1, 8'h30, 8'h30, 0, 0);

    // Load on the step edge: step discarded, prescaler restarts.
    add(0, 1, 1, 0, 8'h00, 8'h30, 0, 0);
    add(0, 1, 1, 0, 8'h00, 8'h30, 0, 0);
    add(0, 1, 1, 0, 8'h00, 8'h30, 0, 0);
    add(0, 1, 1, 1, 8'h45, 8'h45, 0, 0);
    add_steps(1, 4, 8'h45, 8'h46, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply("table", vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load,
            vecs[i].lv, vecs[i].eb, vecs[i].es, vecs[i].ew);

    // Enable dropped mid-interval: prescaler holds at 2, then resumes.
    apply("freeze_pre", 0, 1, 0, 0, 8'h00, 8'h46, 0, 0);
    apply("freeze_pre", 0, 1, 0, 0, 8'h00, 8'h46, 0, 0);
    for (int i = 0; i < 10; i++) apply("freeze_hold", 0, 0, 0, 0, 8'h00, 8'h46, 0, 0);
    apply("freeze_resume", 0, 1, 0, 0, 8'h00, 8'h46, 0, 0);
    apply("freeze_step", 0, 1, 0, 0, 8'h00, 8'h45, 1, 0);

    // Reset with bcd=56 and pcnt=2; first step 4 clocks after release.
    apply("rst_load", 0, 1, 1, 1, 8'h56, 8'h56, 0, 0);
    apply("rst_pre", 0, 1, 1, 0, 8'h00, 8'h56, 0, 0);
    apply("rst_pre", 0, 1, 1, 0, 8'h00, 8'h56, 0, 0);
    apply("rst_mid", 1, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) apply("rst_after", 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    apply("rst_first_step", 0, 1, 1, 0, 8'h00, 8'h01, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
